// File: rtl/rom_dl_if.sv
// ---------------------------------------------------------------------------
// rom_dl_if
// Bundles the HPS ioctl download stream and the core-side dn_* write port.
//
// Handshake: both directions are strobe-only. ioctl_wr qualifies
// ioctl_addr/ioctl_dout for exactly the cycle it is high, and dn_wr
// qualifies dn_addr/dn_data the same way. There is no ready signal; the
// receiver must accept every strobe, so back-to-back strobes are legal.
//
// Modports
//   master : HPS side (drives ioctl_*, observes dn_*)
//   slave  : download controller (consumes ioctl_*, drives dn_*)
// ---------------------------------------------------------------------------
interface rom_dl_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic [3:0]  dn_wr;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr
    );
endinterface

// File: rtl/rom_download_ctrl.sv
// ---------------------------------------------------------------------------
// rom_download_ctrl
// Sequences the HPS ROM download into the arcade core. Each ioctl byte is
// decoded into one of four ROM regions and re-emitted one cycle later with a
// region-local address and a one-hot write strobe. The game core is held in
// reset until a complete, valid image has landed and a settle delay expires.
//
// Ports
//   clk_sys     system clock
//   reset       synchronous, active-high
//   dl          rom_dl_if.slave: ioctl_* in, dn_addr/dn_data/dn_wr out
//   core_reset  game core reset, low only once a valid image is running
//   dl_done     valid image loaded, core running
//   dl_error    last download was invalid
//   byte_count  in-region bytes accepted in the current/last download
//   state_dbg   current FSM state (WAIT=0 LOAD=1 HOLD=2 RUN=3 ERR=4)
// ---------------------------------------------------------------------------
module rom_download_ctrl #(
    parameter logic [24:0] BASE0       = 25'h0000,
    parameter logic [24:0] SIZE0       = 25'h6000,
    parameter logic [24:0] BASE1       = 25'h6000,
    parameter logic [24:0] SIZE1       = 25'h2000,
    parameter logic [24:0] BASE2       = 25'h8000,
    parameter logic [24:0] SIZE2       = 25'h1000,
    parameter logic [24:0] BASE3       = 25'h9000,
    parameter logic [24:0] SIZE3       = 25'h2000,
    parameter logic [24:0] EXPECT      = 25'hB000,
    parameter int unsigned HOLD_CYCLES = 1024
) (
    input  logic        clk_sys,
    input  logic        reset,
    rom_dl_if.slave     dl,
    output logic        core_reset,
    output logic        dl_done,
    output logic        dl_error,
    output logic [24:0] byte_count,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_WAIT = 3'd0,
        S_LOAD = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam int HCW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    state_t          state_q, state_d;
    logic [24:0]     byte_count_q, byte_count_d;
    logic            err_q, err_d;
    logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [3:0]      dn_wr_q, dn_wr_d;
    logic [15:0]     dn_addr_q, dn_addr_d;
    logic [7:0]      dn_data_q, dn_data_d;

    // Decode results for the current ioctl address.
    logic            hit;
    logic [3:0]      hit_strobe;
    logic [15:0]     hit_addr;

    // Range test done one bit wider so BASE+SIZE cannot wrap.
    function automatic logic in_region(input logic [24:0] a,
                                       input logic [24:0] base,
                                       input logic [24:0] size);
        logic [25:0] top;
        top = {1'b0, base} + {1'b0, size};
        return ({1'b0, a} >= {1'b0, base}) && ({1'b0, a} < top);
    endfunction

    // Priority chain: when regions overlap the lowest index claims the byte.
    // The local address only needs the low 16 bits of (addr - base).
    always_comb begin
        hit        = 1'b1;
        hit_strobe = 4'b0000;
        hit_addr   = 16'h0000;
        if (in_region(dl.ioctl_addr, BASE0, SIZE0)) begin
            hit_strobe = 4'b0001;
            hit_addr   = dl.ioctl_addr[15:0] - BASE0[15:0];
        end else if (in_region(dl.ioctl_addr, BASE1, SIZE1)) begin
            hit_strobe = 4'b0010;
            hit_addr   = dl.ioctl_addr[15:0] - BASE1[15:0];
        end else if (in_region(dl.ioctl_addr, BASE2, SIZE2)) begin
            hit_strobe = 4'b0100;
            hit_addr   = dl.ioctl_addr[15:0] - BASE2[15:0];
        end else if (in_region(dl.ioctl_addr, BASE3, SIZE3)) begin
            hit_strobe = 4'b1000;
            hit_addr   = dl.ioctl_addr[15:0] - BASE3[15:0];
        end else begin
            hit = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_count_d = byte_count_q;
        err_d        = err_q;
        hold_cnt_d   = hold_cnt_q;
        dn_wr_d      = 4'b0000;
        dn_addr_d    = dn_addr_q;
        dn_data_d    = dn_data_q;

        case (state_q)
            S_LOAD: begin
                // The last byte may arrive in the same cycle download drops,
                // so the write is handled before the exit test.
                if (dl.ioctl_wr) begin
                    if (hit) begin
                        dn_wr_d   = hit_strobe;
                        dn_addr_d = hit_addr;
                        dn_data_d = dl.ioctl_dout;
                        if (byte_count_q != '1) begin
                            byte_count_d = byte_count_q + 25'd1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (!dl.ioctl_download) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
            end

            S_HOLD: begin
                if (dl.ioctl_download) begin
                    state_d      = S_LOAD;
                    byte_count_d = '0;
                    err_d        = 1'b0;
                    hold_cnt_d   = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = (!err_q && byte_count_q >= EXPECT) ? S_RUN : S_ERR;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            default: begin
                // WAIT, RUN, ERR: only a new download moves us.
                if (dl.ioctl_download) begin
                    state_d      = S_LOAD;
                    byte_count_d = '0;
                    err_d        = 1'b0;
                    hold_cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= S_WAIT;
            byte_count_q <= '0;
            err_q        <= 1'b0;
            hold_cnt_q   <= '0;
            dn_wr_q      <= 4'b0000;
            dn_addr_q    <= 16'h0000;
            dn_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            byte_count_q <= byte_count_d;
            err_q        <= err_d;
            hold_cnt_q   <= hold_cnt_d;
            dn_wr_q      <= dn_wr_d;
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
        end
    end

    assign dl.dn_wr   = dn_wr_q;
    assign dl.dn_addr = dn_addr_q;
    assign dl.dn_data = dn_data_q;

    // Status is a pure decode of the registered state.
    assign core_reset = (state_q != S_RUN);
    assign dl_done    = (state_q == S_RUN);
    assign dl_error   = (state_q == S_ERR);
    assign byte_count = byte_count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_rom_download_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rom_download_ctrl
// Drives the download controller cycle by cycle and compares every output
// against a behavioural model after each clock edge. The region map is
// shrunk (same shape, overlapping regions 2/3) so several full images fit
// in a short run; the settle delay keeps its real length of 1024 cycles.
// ---------------------------------------------------------------------------
module tb_rom_download_ctrl;

    localparam int HOLD = 1024;
    localparam int B0 = 'h0000, S0 = 'h1800;
    localparam int B1 = 'h1800, S1 = 'h0800;
    localparam int B2 = 'h2000, S2 = 'h0800;
    localparam int B3 = 'h2400, S3 = 'h0800;  // 2400..27FF shadowed by region 2
    localparam int EXP = 'h2C00;
    localparam int BASE_T [4] = '{B0, B1, B2, B3};
    localparam int SIZE_T [4] = '{S0, S1, S2, S3};

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_reset, dl_done, dl_error;
    logic [24:0] byte_count;
    logic [2:0]  state_dbg;

    always #5 clk = ~clk;

    rom_dl_if dl_if();

    rom_download_ctrl #(
        .BASE0(25'(B0)), .SIZE0(25'(S0)),
        .BASE1(25'(B1)), .SIZE1(25'(S1)),
        .BASE2(25'(B2)), .SIZE2(25'(S2)),
        .BASE3(25'(B3)), .SIZE3(25'(S3)),
        .EXPECT(25'(EXP)), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk_sys   (clk),
        .reset     (reset),
        .dl        (dl_if),
        .core_reset(core_reset),
        .dl_done   (dl_done),
        .dl_error  (dl_error),
        .byte_count(byte_count),
        .state_dbg (state_dbg)
    );

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_EMPTY, M_LOADING, M_SETTLING, M_RUNNING, M_FAILED} mphase_t;
    mphase_t     m_ph = M_EMPTY;
    int          m_cnt = 0;
    bit          m_bad = 1'b0;
    int          m_settle = 0;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_data = '0;
    logic [27:0] exp_q[$];   // {dn_wr, dn_addr, dn_data} expected after each edge

    function automatic int region_of(input logic [24:0] a);
        for (int n = 0; n < 4; n++) begin
            if (int'(a) >= BASE_T[n] && int'(a) < BASE_T[n] + SIZE_T[n]) return n;
        end
        return -1;
    endfunction

    task automatic model_edge(input bit rst, input bit dl, input bit wr,
                              input logic [24:0] a, input logic [7:0] d);
        logic [3:0] s;
        int r;
        s = 4'b0000;
        if (rst) begin
            m_ph = M_EMPTY; m_cnt = 0; m_bad = 1'b0; m_settle = 0;
            m_addr = '0; m_data = '0;
        end else if (m_ph == M_LOADING) begin
            if (wr) begin
                r = region_of(a);
                if (r < 0) begin
                    m_bad = 1'b1;
                end else begin
                    s = 4'(1 << r);
                    m_addr = 16'(int'(a) - BASE_T[r]);
                    m_data = d;
                    if (m_cnt < 'h1FFFFFF) m_cnt++;
                end
            end
            if (!dl) begin
                m_ph = M_SETTLING;
                m_settle = 0;
            end
        end else if (dl) begin
            m_ph = M_LOADING; m_cnt = 0; m_bad = 1'b0;
        end else if (m_ph == M_SETTLING) begin
            m_settle++;
            if (m_settle == HOLD) m_ph = (!m_bad && m_cnt >= EXP) ? M_RUNNING : M_FAILED;
        end
        exp_q.push_back({s, m_addr, m_data});
    endtask

    // ---------------- scoreboard ----------------
    task automatic sample_check();
        logic [27:0] e;
        e = exp_q.pop_front();
        check_eq("dn_wr",      32'(dl_if.dn_wr),   32'(e[27:24]));
        check_eq("dn_addr",    32'(dl_if.dn_addr), 32'(e[23:8]));
        check_eq("dn_data",    32'(dl_if.dn_data), 32'(e[7:0]));
        check_eq("core_reset", 32'(core_reset),    32'(m_ph != M_RUNNING));
        check_eq("dl_done",    32'(dl_done),       32'(m_ph == M_RUNNING));
        check_eq("dl_error",   32'(dl_error),      32'(m_ph == M_FAILED));
        check_eq("byte_count", 32'(byte_count),    32'(m_cnt));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit rst, input bit dl, input bit wr,
                         input logic [24:0] a, input logic [7:0] d);
        reset                = rst;
        dl_if.ioctl_download = dl;
        dl_if.ioctl_wr       = wr;
        dl_if.ioctl_addr     = a;
        dl_if.ioctl_dout     = d;
        model_edge(rst, dl, wr, a, d);
        @(posedge clk);
        #1;
        sample_check();
    endtask

    // Download low; stray ioctl_wr pulses must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'($urandom_range(0, 1)),
                  25'($urandom_range(0, 'h2FFF)), 8'($urandom_range(0, 255)));
        end
    endtask

    // Back-to-back writes lo..hi; optionally drop download with the last one.
    task automatic load_range(input int lo, input int hi, input bit fall_last);
        logic [7:0] d;
        for (int a = lo; a <= hi; a++) begin
            d = (a == B1 + 5) ? 8'h3C : 8'($urandom_range(0, 255));
            drive(1'b0, !(fall_last && a == hi), 1'b1, 25'(a), d);
            if (a == B1 + 5) begin
                check_eq("spot_wr",   32'(dl_if.dn_wr),   32'h2);
                check_eq("spot_addr", 32'(dl_if.dn_addr), 32'h5);
                check_eq("spot_data", 32'(dl_if.dn_data), 32'h3C);
            end
        end
    endtask

    task automatic start_dl();
        drive(1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    // ---------------- stimulus ----------------
    int  hold_len;
    int  len;
    logic [24:0] ra;

    initial begin
        // Reset, then idle.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 100; i++) begin
            idle(1);
            check_eq("idle_core_reset", 32'(core_reset), 32'h1);
            check_eq("idle_dl_done",    32'(dl_done),    32'h0);
            check_eq("idle_dn_wr",      32'(dl_if.dn_wr), 32'h0);
        end

        // Short image: must end in ERR.
        start_dl();
        load_range(0, 'hFFF, 1'b1);
        idle(HOLD + 5);
        check_eq("short_err",   32'(dl_error),   32'h1);
        check_eq("short_reset", 32'(core_reset), 32'h1);
        check_eq("short_count", 32'(byte_count), 32'h1000);

        // Full image plus a stray out-of-map write: no strobe, ERR.
        start_dl();
        load_range(0, EXP - 1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 25'h0C000, 8'hA5);
        check_eq("miss_wr", 32'(dl_if.dn_wr), 32'h0);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        idle(HOLD + 5);
        check_eq("miss_err",   32'(dl_error),   32'h1);
        check_eq("miss_count", 32'(byte_count), 32'(EXP));

        // Re-assert download 10 cycles into the settle delay.
        start_dl();
        load_range(0, 'hFFF, 1'b1);
        idle(9);
        start_dl();
        check_eq("rearm_count", 32'(byte_count), 32'h0);
        check_eq("rearm_reset", 32'(core_reset), 32'h1);

        // Full image with the final write on the falling edge of download.
        load_range(0, EXP - 1, 1'b1);
        hold_len = 0;
        while (core_reset && hold_len < 3000) begin
            hold_len++;
            idle(1);
        end
        check_eq("hold_len",   32'(hold_len),   32'(HOLD));
        check_eq("run_done",   32'(dl_done),    32'h1);
        check_eq("run_count",  32'(byte_count), 32'(EXP));
        idle(20);

        // Reset in the same cycle as a write in LOAD.
        start_dl();
        load_range(0, 20, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 25'h30, 8'h55);
        check_eq("rst_wr",    32'(dl_if.dn_wr), 32'h0);
        check_eq("rst_count", 32'(byte_count),  32'h0);
        check_eq("rst_reset", 32'(core_reset),  32'h1);
        check_eq("rst_done",  32'(dl_done),     32'h0);
        idle(5);

        // Randomized sessions: gaps, misses, aliased high addresses,
        // download dropouts, occasional reset, holds cut short.
        for (int s = 0; s < 16; s++) begin
            start_dl();
            if (s == 7) begin
                load_range(0, EXP - 1, 1'b1);
            end else begin
                len = $urandom_range(0, 400);
                for (int i = 0; i < len; i++) begin
                    case ($urandom_range(0, 9))
                        0:       ra = 25'($urandom_range(0, 32'h1FFFFFF));
                        1:       ra = 25'h1000000 | 25'($urandom_range(0, 'h3FFF));
                        default: ra = 25'($urandom_range(0, 'h2FFF));
                    endcase
                    drive(1'($urandom_range(0, 499) == 0),
                          1'($urandom_range(0, 99) != 0),
                          1'($urandom_range(0, 3) != 0),
                          ra, 8'($urandom_range(0, 255)));
                end
                drive(1'b0, 1'b0, 1'b0, '0, '0);
            end
            idle($urandom_range(0, 1300));
        end
        idle(HOLD + 5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
